// File: rtl/toy_fetch_queue_pkg.sv
// toy_fetch_queue_pkg: default geometry and modular pointer arithmetic shared by the fetch queue
package toy_fetch_queue_pkg;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_ENQ_WIDTH = 2;
    localparam int DEF_DEQ_WIDTH = 2;

    // ptr < depth and n <= depth, so one conditional subtract is enough to wrap any depth
    function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned n, input int unsigned depth);
        int unsigned s;
        s = ptr + n;
        return (s >= depth) ? s - depth : s;
    endfunction
endpackage

// File: rtl/toy_lead_ones_cnt.sv
// toy_lead_ones_cnt: counts consecutive ones starting at bit 0
// ports: i_vec - input vector; o_cnt - number of leading ones from bit 0
module toy_lead_ones_cnt #(
    parameter int WIDTH = 2,
    localparam int NW = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [NW-1:0]    o_cnt
);
    logic w_run;
    always_comb begin
        o_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_run = w_run & i_vec[i];
            o_cnt = o_cnt + NW'(w_run);
        end
    end
endmodule

// File: rtl/toy_fetch_queue_mw.sv
// toy_fetch_queue_mw: multi-lane in-order fetch queue, N-wide enqueue / M-wide dequeue
// ports: i_clk/i_rst (sync, active high), i_clear (flush); i_req_vld/o_req_rdy/i_req_pld enqueue lanes
//        (lane 0 oldest); o_ack_vld/i_ack_rdy/o_ack_pld dequeue lanes (lane 0 oldest);
//        o_occ_cnt entries held, o_free_cnt slots free
module toy_fetch_queue_mw
    import toy_fetch_queue_pkg::*;
#(
    parameter int  DEPTH     = DEF_DEPTH,
    parameter int  ENQ_WIDTH = DEF_ENQ_WIDTH,
    parameter int  DEQ_WIDTH = DEF_DEQ_WIDTH,
    parameter type PLD_TYPE  = logic [31:0],
    localparam int AWIDTH    = $clog2(DEPTH),
    localparam int CWIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic [ENQ_WIDTH-1:0] i_req_vld,
    output logic                 o_req_rdy,
    input  PLD_TYPE              i_req_pld [ENQ_WIDTH],
    output logic [DEQ_WIDTH-1:0] o_ack_vld,
    input  logic [DEQ_WIDTH-1:0] i_ack_rdy,
    output PLD_TYPE              o_ack_pld [DEQ_WIDTH],
    output logic [CWIDTH-1:0]    o_occ_cnt,
    output logic [CWIDTH-1:0]    o_free_cnt
);
    localparam int EW = $clog2(ENQ_WIDTH + 1);
    localparam int DW = $clog2(DEQ_WIDTH + 1);

    PLD_TYPE           r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [CWIDTH-1:0] r_cnt;
    logic [EW-1:0]     w_push_raw, w_push_n;
    logic [DW-1:0]     w_pop_n;
    logic [CWIDTH:0]   w_cnt_nxt;
    logic [AWIDTH-1:0] w_wr_idx [ENQ_WIDTH];
    logic [AWIDTH-1:0] w_rd_idx [DEQ_WIDTH];
    logic [ENQ_WIDTH-1:0] w_wen;

    toy_lead_ones_cnt #(.WIDTH(ENQ_WIDTH)) u_push_cnt (.i_vec(i_req_vld), .o_cnt(w_push_raw));
    toy_lead_ones_cnt #(.WIDTH(DEQ_WIDTH)) u_pop_cnt (.i_vec(o_ack_vld & i_ack_rdy), .o_cnt(w_pop_n));

    // ready depends on registered count only, so a same-cycle pop never widens acceptance
    assign o_free_cnt = CWIDTH'(DEPTH) - r_cnt;
    assign o_occ_cnt  = r_cnt;
    assign o_req_rdy  = o_free_cnt >= CWIDTH'(ENQ_WIDTH);
    assign w_push_n   = o_req_rdy ? w_push_raw : '0;
    assign w_cnt_nxt  = {1'b0, r_cnt} + (CWIDTH + 1)'(w_push_n) - (CWIDTH + 1)'(w_pop_n);

    genvar i;
    generate
        for (i = 0; i < ENQ_WIDTH; i++) begin : g_wr
            assign w_wr_idx[i] = AWIDTH'(ptr_add(32'(r_wr_ptr), i, DEPTH));
            assign w_wen[i]    = !i_rst && !i_clear && (w_push_n > EW'(i));
        end
        for (i = 0; i < DEQ_WIDTH; i++) begin : g_rd
            assign w_rd_idx[i]  = AWIDTH'(ptr_add(32'(r_rd_ptr), i, DEPTH));
            assign o_ack_vld[i] = r_cnt > CWIDTH'(i);
            assign o_ack_pld[i] = r_mem[w_rd_idx[i]];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++)
            if (w_wen[k]) r_mem[w_wr_idx[k]] <= i_req_pld[k];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= AWIDTH'(ptr_add(32'(r_wr_ptr), 32'(w_push_n), DEPTH));
            r_rd_ptr <= AWIDTH'(ptr_add(32'(r_rd_ptr), 32'(w_pop_n), DEPTH));
            r_cnt    <= CWIDTH'(w_cnt_nxt);
        end
    end
endmodule

// File: tb/tb_toy_fetch_queue_mw.sv
// tb_toy_fetch_queue_mw: directed self-checking bench for the multi-lane fetch queue
module tb_toy_fetch_queue_mw;
    logic clk = 0, rst = 1, clear = 0;
    always #5 clk = ~clk;

    logic [1:0]  a_req_vld = 0, a_ack_vld, a_ack_rdy = 0;
    logic        a_req_rdy;
    logic [31:0] a_req_pld [2];
    logic [31:0] a_ack_pld [2];
    logic [4:0]  a_occ, a_free;

    logic [1:0]  b_req_vld = 0;
    logic [0:0]  b_ack_vld, b_ack_rdy = 0;
    logic        b_req_rdy;
    logic [31:0] b_req_pld [2];
    logic [31:0] b_ack_pld [1];
    logic [2:0]  b_occ, b_free;

    int cmp = 0, errs = 0;

    toy_fetch_queue_mw #(.DEPTH(16), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_req_vld(a_req_vld), .o_req_rdy(a_req_rdy),
        .i_req_pld(a_req_pld), .o_ack_vld(a_ack_vld), .i_ack_rdy(a_ack_rdy), .o_ack_pld(a_ack_pld),
        .o_occ_cnt(a_occ), .o_free_cnt(a_free));

    toy_fetch_queue_mw #(.DEPTH(6), .ENQ_WIDTH(2), .DEQ_WIDTH(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_req_vld(b_req_vld), .o_req_rdy(b_req_rdy),
        .i_req_pld(b_req_pld), .o_ack_vld(b_ack_vld), .i_ack_rdy(b_ack_rdy), .o_ack_pld(b_ack_pld),
        .o_occ_cnt(b_occ), .o_free_cnt(b_free));

    always @(negedge clk) begin
        assert (a_occ <= 5'd16 && b_occ <= 3'd6 && a_occ + a_free == 6'd16)
        else begin
            errs++;
            $display("FAIL invariant occ_a=%0d free_a=%0d occ_b=%0d", a_occ, a_free, b_occ);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [1:0] v, input int p0, input int p1);
        a_req_vld = v;
        a_req_pld[0] = 32'(p0);
        a_req_pld[1] = 32'(p1);
        step();
        a_req_vld = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        rst = 0;
        cmp++; if (a_ack_vld !== 2'b00) begin errs++; $display("FAIL rst_ack_vld got %b want 00", a_ack_vld); end
        cmp++; if (a_req_rdy !== 1'b1) begin errs++; $display("FAIL rst_req_rdy got %b want 1", a_req_rdy); end
        cmp++; if (a_occ !== 5'd0) begin errs++; $display("FAIL rst_occ got %0d want 0", a_occ); end
        cmp++; if (a_free !== 5'd16) begin errs++; $display("FAIL rst_free got %0d want 16", a_free); end
    endtask

    task automatic test_fill_drain();
        a_ack_rdy = 2'b00;
        for (int k = 0; k < 8; k++) begin
            cmp++; if (a_req_rdy !== 1'b1) begin errs++; $display("FAIL fill_rdy k=%0d got %b want 1", k, a_req_rdy); end
            push_a(2'b11, 2 * k, 2 * k + 1);
        end
        cmp++; if (a_req_rdy !== 1'b0) begin errs++; $display("FAIL full_rdy got %b want 0", a_req_rdy); end
        cmp++; if (a_occ !== 5'd16) begin errs++; $display("FAIL full_occ got %0d want 16", a_occ); end
        cmp++; if (a_free !== 5'd0) begin errs++; $display("FAIL full_free got %0d want 0", a_free); end
        a_ack_rdy = 2'b11;
        for (int k = 0; k < 8; k++) begin
            cmp++; if (a_ack_vld !== 2'b11) begin errs++; $display("FAIL drain_vld k=%0d got %b want 11", k, a_ack_vld); end
            cmp++; if (a_ack_pld[0] !== 32'(2 * k)) begin errs++; $display("FAIL drain_l0 k=%0d got %0d want %0d", k, a_ack_pld[0], 2 * k); end
            cmp++; if (a_ack_pld[1] !== 32'(2 * k + 1)) begin errs++; $display("FAIL drain_l1 k=%0d got %0d want %0d", k, a_ack_pld[1], 2 * k + 1); end
            step();
        end
        a_ack_rdy = 2'b00;
        cmp++; if (a_occ !== 5'd0) begin errs++; $display("FAIL drain_occ got %0d want 0", a_occ); end
        cmp++; if (a_ack_vld !== 2'b00) begin errs++; $display("FAIL empty_vld got %b want 00", a_ack_vld); end
    endtask

    task automatic test_partial();
        push_a(2'b01, 100, 101);
        cmp++; if (a_occ !== 5'd1) begin errs++; $display("FAIL part_push1 got %0d want 1", a_occ); end
        cmp++; if (a_ack_vld !== 2'b01) begin errs++; $display("FAIL part_vld got %b want 01", a_ack_vld); end
        cmp++; if (a_ack_pld[0] !== 32'd100) begin errs++; $display("FAIL part_pld got %0d want 100", a_ack_pld[0]); end
        push_a(2'b10, 200, 201);
        cmp++; if (a_occ !== 5'd1) begin errs++; $display("FAIL part_push0 got %0d want 1", a_occ); end
        push_a(2'b01, 102, 103);
        cmp++; if (a_ack_pld[1] !== 32'd102) begin errs++; $display("FAIL part_l1 got %0d want 102", a_ack_pld[1]); end
        a_ack_rdy = 2'b10;
        step();
        cmp++; if (a_occ !== 5'd2) begin errs++; $display("FAIL part_pop0 got %0d want 2", a_occ); end
        a_ack_rdy = 2'b01;
        step();
        cmp++; if (a_occ !== 5'd1) begin errs++; $display("FAIL part_pop1 got %0d want 1", a_occ); end
        cmp++; if (a_ack_pld[0] !== 32'd102) begin errs++; $display("FAIL part_realign got %0d want 102", a_ack_pld[0]); end
        a_ack_rdy = 2'b11;
        step();
        a_ack_rdy = 2'b00;
        cmp++; if (a_occ !== 5'd0) begin errs++; $display("FAIL part_empty got %0d want 0", a_occ); end
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 7; k++) push_a(2'b11, 300 + 2 * k, 301 + 2 * k);
        push_a(2'b01, 314, 0);
        cmp++; if (a_occ !== 5'd15) begin errs++; $display("FAIL fp_occ got %0d want 15", a_occ); end
        cmp++; if (a_req_rdy !== 1'b0) begin errs++; $display("FAIL fp_rdy got %b want 0", a_req_rdy); end
        a_ack_rdy = 2'b11;
        push_a(2'b11, 900, 901);
        a_ack_rdy = 2'b00;
        cmp++; if (a_occ !== 5'd13) begin errs++; $display("FAIL fp_occ2 got %0d want 13", a_occ); end
        cmp++; if (a_req_rdy !== 1'b1) begin errs++; $display("FAIL fp_rdy2 got %b want 1", a_req_rdy); end
        cmp++; if (a_ack_pld[0] !== 32'd302) begin errs++; $display("FAIL fp_head got %0d want 302", a_ack_pld[0]); end
    endtask

    task automatic test_clear();
        clear = 1;
        step();
        clear = 0;
        push_a(2'b11, 400, 401);
        push_a(2'b11, 402, 403);
        push_a(2'b01, 404, 0);
        cmp++; if (a_occ !== 5'd5) begin errs++; $display("FAIL clr_pre got %0d want 5", a_occ); end
        cmp++; if (a_ack_pld[1] !== 32'd401) begin errs++; $display("FAIL clr_pre_l1 got %0d want 401", a_ack_pld[1]); end
        clear = 1;
        a_ack_rdy = 2'b11;
        push_a(2'b11, 500, 501);
        clear = 0;
        a_ack_rdy = 2'b00;
        cmp++; if (a_occ !== 5'd0) begin errs++; $display("FAIL clr_occ got %0d want 0", a_occ); end
        cmp++; if (a_ack_vld !== 2'b00) begin errs++; $display("FAIL clr_vld got %b want 00", a_ack_vld); end
        cmp++; if (a_req_rdy !== 1'b1) begin errs++; $display("FAIL clr_rdy got %b want 1", a_req_rdy); end
        push_a(2'b01, 600, 0);
        cmp++; if (a_ack_vld !== 2'b01) begin errs++; $display("FAIL clr_next_vld got %b want 01", a_ack_vld); end
        cmp++; if (a_ack_pld[0] !== 32'd600) begin errs++; $display("FAIL clr_next_pld got %0d want 600", a_ack_pld[0]); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) push_a(2'b11, 700 + 2 * k, 701 + 2 * k);
        cmp++; if (a_occ !== 5'd7) begin errs++; $display("FAIL rm_pre got %0d want 7", a_occ); end
        rst = 1;
        a_ack_rdy = 2'b11;
        push_a(2'b11, 800, 801);
        rst = 0;
        a_ack_rdy = 2'b00;
        cmp++; if (a_ack_vld !== 2'b00) begin errs++; $display("FAIL rm_vld got %b want 00", a_ack_vld); end
        cmp++; if (a_req_rdy !== 1'b1) begin errs++; $display("FAIL rm_rdy got %b want 1", a_req_rdy); end
        cmp++; if (a_occ !== 5'd0) begin errs++; $display("FAIL rm_occ got %0d want 0", a_occ); end
        cmp++; if (a_free !== 5'd16) begin errs++; $display("FAIL rm_free got %0d want 16", a_free); end
    endtask

    task automatic test_wrap();
        int nv = 0, exp = 0, cyc = 0;
        while (exp < 30 && cyc < 500) begin
            b_req_vld = (nv <= 28) ? 2'b11 : (nv == 29) ? 2'b01 : 2'b00;
            b_req_pld[0] = 32'(nv);
            b_req_pld[1] = 32'(nv + 1);
            b_ack_rdy = 1'($urandom_range(0, 1));
            if (b_req_rdy) nv += (b_req_vld == 2'b11) ? 2 : (b_req_vld == 2'b01) ? 1 : 0;
            if (b_ack_vld[0] && b_ack_rdy[0]) begin
                cmp++; if (b_ack_pld[0] !== 32'(exp)) begin errs++; $display("FAIL wrap_pld got %0d want %0d", b_ack_pld[0], exp); end
                exp++;
            end
            step();
            cyc++;
        end
        b_req_vld = 0;
        b_ack_rdy = 0;
        cmp++; if (exp != 30) begin errs++; $display("FAIL wrap_timeout got %0d want 30", exp); end
        cmp++; if (b_occ !== 3'd0) begin errs++; $display("FAIL wrap_occ got %0d want 0", b_occ); end
    endtask

    initial begin
        a_req_pld[0] = 0; a_req_pld[1] = 0;
        b_req_pld[0] = 0; b_req_pld[1] = 0;
        test_reset();
        test_fill_drain();
        test_partial();
        test_full_pop();
        test_clear();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/toy_fetch_queue_mw.md
# toy_fetch_queue_mw

Multi-lane fetch queue between the fetch unit and decode. Each cycle it accepts up to `ENQ_WIDTH` in-order fetch packets and presents up to `DEQ_WIDTH` oldest packets to decode. It is the parametrised successor of the single-lane fetch queue. Additions over that queue: N-wide enqueue, M-wide dequeue, partial-pop, non-power-of-two depth, and occupancy/free-count outputs for fetch throttling.

## Interface
- `DEPTH`, 16, number of entries; any integer ≥ max(`ENQ_WIDTH`, `DEQ_WIDTH`), need not be a power of two
- `ENQ_WIDTH`, 2, enqueue lanes
- `DEQ_WIDTH`, 2, dequeue lanes
- `PLD_TYPE`, `logic[31:0]`, per-entry payload type
- `AWIDTH`, `$clog2(DEPTH)`, local: pointer width
- `CWIDTH`, `$clog2(DEPTH+1)`, local: count width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `clear`  in  1  synchronous flush; empties the queue
- `req_vld`  in  `ENQ_WIDTH`  per-lane enqueue valid; lane 0 is the oldest
- `req_rdy`  out  1  queue can take a full `ENQ_WIDTH` group this cycle
- `req_pld`  in  `ENQ_WIDTH`×`PLD_TYPE`  enqueue payloads
- `ack_vld`  out  `DEQ_WIDTH`  per-lane dequeue valid; lane 0 is the oldest entry
- `ack_rdy`  in  `DEQ_WIDTH`  per-lane consumer ready
- `ack_pld`  out  `DEQ_WIDTH`×`PLD_TYPE`  dequeue payloads
- `occ_cnt`  out  `CWIDTH`  current entry count
- `free_cnt`  out  `CWIDTH`  `DEPTH - occ_cnt`

## Operation
- **State:** `wr_ptr`, `rd_ptr` (AWIDTH each), `cnt` (CWIDTH), and a payload memory of `DEPTH` entries.
- **Enqueue count:** `push_n` = number of leading ones of `req_vld` (starting at lane 0), gated by `req_rdy`.
  - Lanes after the first zero are ignored even if set.
  - Lane i is written to `mem[(wr_ptr+i) mod DEPTH]`.
- **Enqueue ready:** `req_rdy = (free_cnt >= ENQ_WIDTH)`.
  - Computed from registered `cnt` only, with no path from `ack_rdy`.
  - It is all-or-nothing: no partial acceptance at a near-full boundary.
- **Dequeue valid and payload:**
  - `ack_vld[i] = (cnt > i)`.
  - `ack_pld[i] = mem[(rd_ptr+i) mod DEPTH]`.
  - When `ack_vld[i]=0`, `ack_pld[i]` is don't-care.
- **Dequeue count:** `pop_n` = number of leading ones of `ack_vld & ack_rdy`.
  - The consumer pops in order; a ready on lane 1 without lane 0 pops nothing.
- **Pointer update:**
  - `wr_ptr <= (wr_ptr + push_n) mod DEPTH`.
  - `rd_ptr <= (rd_ptr + pop_n) mod DEPTH`.
  - Wrap is computed by compare-and-subtract, not by truncation, so non-power-of-two `DEPTH` is correct.
- **Count update:** `cnt <= cnt + push_n - pop_n`, evaluated at CWIDTH+1 bits. Push and pop in the same cycle are both honoured.
- **Priority:** `rst` > `clear` > push/pop.
  - `clear` zeroes `wr_ptr`, `rd_ptr` and `cnt`.
  - Push and pop in the clear cycle are discarded.
  - The memory is not cleared.
- **Outputs:** `occ_cnt = cnt`; `free_cnt = DEPTH - cnt`.

## Timing
- **Reset values:**
  - `ack_vld` = 0
  - `req_rdy` = 1
  - `occ_cnt` = 0
  - `free_cnt` = `DEPTH`
  - `ack_pld` = X, permitted
- **Latency:** a pushed entry appears on `ack_*` the cycle after its push. There is no same-cycle bypass.
- **Pop effect:** a popped entry leaves `ack_*` the next cycle. Lanes re-align so the next oldest entry is on lane 0.
- **Full:** with `free_cnt < ENQ_WIDTH`, `req_rdy=0` even if a pop happens in the same cycle; the freed slots are visible next cycle.
- **Empty:** with `cnt=0`, all `ack_vld=0` and `pop_n=0` regardless of `ack_rdy`.
- **Reset/clear mid-operation:** an assertion at any cycle gives an empty queue and `req_rdy=1` in the next cycle.
- **Invariant:** `cnt` never exceeds `DEPTH` and never underflows. The bench asserts this.

## Structure
- **Shared package `toy_fetch_queue_pkg`:** holds the default `DEPTH`/`ENQ_WIDTH`/`DEQ_WIDTH` constants and the function `ptr_add(ptr, n, DEPTH)` (modular add).
- **Sub-module `toy_lead_ones_cnt #(WIDTH)`:** combinational count of leading ones from bit 0. It is instantiated twice, once for `push_n` and once for `pop_n`.
- **Memory:** a flop array, with per-lane write/read muxes generated in a loop.

## Test plan
- **Fill and drain:** `DEPTH=16`, ENQ=DEQ=2, push 8 groups `{2k, 2k+1}` with `ack_rdy=0`.
  - Required: `req_rdy` falls after the 8th group and `occ_cnt=16`.
  - Then assert `ack_rdy=2'b11`: payloads 0…15 emerge in order, two per cycle.
- **Partial push and partial pop:**
  - `req_vld=2'b01` pushes 1.
  - `req_vld=2'b10` pushes 0.
  - `ack_rdy=2'b10` with 2 entries pops 0.
  - `ack_rdy=2'b01` pops 1.
- **Simultaneous push/pop at `cnt=15`:**
  - `req_rdy=0`, so the push of 2 is rejected; pop 2 gives `cnt=13`.
  - Next cycle `req_rdy=1`.
- **Non-power-of-two wrap:** `DEPTH=6`, ENQ=2, DEQ=1, stream 30 sequential values with random `ack_rdy`.
  - Required: output is exactly 0…29 with no loss or duplication across pointer wrap.
- **Clear mid-stream:** with `cnt=5`, assert `clear` together with a push and a pop.
  - Required: next cycle `occ_cnt=0`, `ack_vld=0`, `req_rdy=1`.
  - The next push value appears on lane 0.
- **Reset:** with `cnt=7`, assert `rst` for 1 cycle.
  - Required: next cycle outputs match the reset values; `free_cnt=DEPTH`.
